// File: rtl/pkg_hamming.sv
// Shared Hamming(7,4) definitions: serialiser states, codeword bit positions
// and the encoder function used by both the transmit and receive sides.
package pkg_hamming;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_W = 4;
  localparam int CW_W   = 7;

  // Codeword layout c[6:0] = {d3,d2,d1,p4,d0,p2,p1}
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    c         = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[P4_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/module_codificador.sv
// Combinational Hamming(7,4) encoder: nibble in, 7-bit codeword out.
module module_codificador
  import pkg_hamming::*;
(
  input  logic [DATA_W-1:0] datos,
  output logic [CW_W-1:0]   codigo
);

  assign codigo = hamming74_encode(datos);

endmodule

// File: rtl/module_codificador_tx.sv
// Hamming(7,4) transmitter: accepts a nibble, encodes it with optional single-bit
// error injection, and serialises the codeword as a start/7 data/stop frame.
module module_codificador_tx
  import pkg_hamming::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datos_in,
  input  logic              valid_in,
  output logic              ready,
  input  logic [2:0]        err_pos,
  output logic [CW_W-1:0]   datos_cod,
  output logic              cod_valid,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(CW_W - 1);

  tx_state_t         state_reg, state_next;
  logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [CW_W-1:0]   datos_cod_reg, datos_cod_next;
  logic              tx_reg, tx_next;
  logic              cod_valid_reg, cod_valid_next;
  logic              done_reg, done_next;

  logic [CW_W-1:0]   codigo;
  logic [CW_W-1:0]   err_mask;
  logic              baud_wrap;

  module_codificador u_codificador (
    .datos  (datos_in),
    .codigo (codigo)
  );

  // err_pos is 1-based; zero means no injected error
  assign err_mask  = (err_pos == 3'd0) ? '0 : (CW_W'(1) << (err_pos - 3'd1));
  assign baud_wrap = (baud_cnt_reg == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      datos_cod_reg <= '0;
      tx_reg        <= 1'b1;
      cod_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      datos_cod_reg <= datos_cod_next;
      tx_reg        <= tx_next;
      cod_valid_reg <= cod_valid_next;
      done_reg      <= done_next;
    end
  end

  // tx is computed one step ahead so the line level tracks the registered state exactly
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    datos_cod_next = datos_cod_reg;
    tx_next        = tx_reg;
    cod_valid_next = 1'b0;
    done_next      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (valid_in) begin
          state_next     = START;
          baud_cnt_next  = '0;
          bit_idx_next   = '0;
          datos_cod_next = codigo ^ err_mask;
          cod_valid_next = 1'b1;
          tx_next        = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next    = DATA;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          tx_next       = datos_cod_reg[0];
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = datos_cod_reg[bit_idx_next];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_next    = IDLE;
          baud_cnt_next = '0;
          done_next     = 1'b1;
          tx_next       = 1'b1;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign ready     = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign datos_cod = datos_cod_reg;
  assign tx        = tx_reg;
  assign cod_valid = cod_valid_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_module_codificador_tx.sv
// Randomised scoreboard bench for module_codificador_tx with a generic
// Hamming reference model and a frame-level serial monitor.
module tb_module_codificador_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] datos_in = '0;
  logic       valid_in = 1'b0;
  logic [2:0] err_pos = '0;
  logic       ready, cod_valid, tx, busy, done;
  logic [6:0] datos_cod;

  typedef struct packed {
    logic [3:0] d;
    logic [6:0] cw;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   done_cnt = 0;

  module_codificador_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .datos_in  (datos_in),
    .valid_in  (valid_in),
    .ready     (ready),
    .err_pos   (err_pos),
    .datos_cod (datos_cod),
    .cod_valid (cod_valid),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Generic Hamming: codeword position p (1..7) lives at bit p-1; parity at powers of two
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] c;
    logic p;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p ^= c[pos-1];
      c[(1 << k) - 1] = p;
    end
    return c;
  endfunction

  function automatic logic [6:0] ref_mask(input logic [2:0] e);
    logic [6:0] one;
    one = 7'd1;
    return (e == 3'd0) ? 7'd0 : (one << (e - 3'd1));
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] cw);
    logic [6:0] c;
    int syn;
    c = cw;
    syn = 0;
    for (int pos = 1; pos <= 7; pos++) if (c[pos-1]) syn ^= pos;
    if (syn != 0) c[syn-1] = ~c[syn-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic exp_bit(input logic [6:0] cw, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b == 8) return 1'b1;
    return cw[b-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops expectation on each cod_valid, then follows the whole frame
  txn_t mon_t;
  int   mon_errs;
  bit   mon_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cod_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cod_valid", 32'd1, 32'd0);
        end else begin
          mon_t = exp_q.pop_front();
          check("datos_cod", {25'd0, datos_cod}, {25'd0, mon_t.cw});
          check("decode", {28'd0, ref_decode(datos_cod)}, {28'd0, mon_t.d});
          mon_errs = 0;
          mon_abort = 1'b0;
          for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (rst) begin
              mon_abort = 1'b1;
              break;
            end
            if (tx !== exp_bit(mon_t.cw, i) || busy !== 1'b1) mon_errs++;
          end
          if (!mon_abort) begin
            check("frame_tx", mon_errs, 0);
            @(negedge clk);
            if (!rst) check("frame_end_done_busy_ready", {29'd0, done, busy, ready}, 32'b101);
          end
          $display("txn d=%h cw=%b frame %s", mon_t.d, mon_t.cw, mon_abort ? "aborted" : "complete");
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic [2:0] e);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    datos_in = d;
    err_pos  = e;
    valid_in = 1'b1;
    exp_q.push_back('{d: d, cw: ref_encode(d) ^ ref_mask(e)});
    @(negedge clk);
    valid_in = 1'b0;
    datos_in = 4'($urandom);
    err_pos  = 3'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !ready) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  int cnt;
  int dc;
  initial begin
    // Reset held for three cycles, then released
    repeat (3) @(negedge clk);
    check("reset_state", {20'd0, tx, ready, busy, done, cod_valid, datos_cod}, {20'd0, 5'b11000, 7'd0});
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_state", {20'd0, tx, ready, busy, done, cod_valid, datos_cod}, {20'd0, 5'b11000, 7'd0});
    end

    // Directed nibble 0001: codeword and done latency
    send(4'b0001, 3'd0);
    check("d1_cw", {25'd0, datos_cod}, 32'b0000111);
    check("d1_first_cycle", {29'd0, cod_valid, tx, busy}, 32'b101);
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("d1_done_latency", cnt, 36);
    wait_idle();

    send(4'b0010, 3'd0);
    check("d2_cw", {25'd0, datos_cod}, 32'b0011001);
    wait_idle();
    send(4'b0001, 3'd3);
    check("d1_err3_cw", {25'd0, datos_cod}, 32'b0000011);
    wait_idle();

    // Full sweep: every nibble with every injection position
    for (int e = 0; e < 8; e++)
      for (int d = 0; d < 16; d++)
        send(4'(d), 3'(e));
    wait_idle();

    // valid_in while busy is ignored; accept in the done cycle starts immediately
    send(4'h5, 3'd0);
    repeat (10) @(negedge clk);
    datos_in = 4'hF;
    err_pos  = 3'd0;
    valid_in = 1'b1;
    check("busy_ready_low", {31'd0, ready}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    check("ignored_keeps_cod", {25'd0, datos_cod}, {25'd0, ref_encode(4'h5)});
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    datos_in = 4'h9;
    err_pos  = 3'd0;
    valid_in = 1'b1;
    exp_q.push_back('{d: 4'h9, cw: ref_encode(4'h9)});
    @(negedge clk);
    valid_in = 1'b0;
    check("b2b_start", {30'd0, cod_valid, tx}, 32'b10);
    wait_idle();

    // Asynchronous reset during data bit 3
    send(4'h6, 3'd0);
    repeat (4 * CPB + 1) @(negedge clk);
    check("pre_rst_in_data", {30'd0, busy, tx}, {30'd0, 1'b1, ref_encode(4'h6)[3]});
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_out", {22'd0, tx, busy, ready, datos_cod}, {22'd0, 3'b101, 7'd0});
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("no_done_after_abort", done_cnt, dc);
    send(4'hB, 3'd4);
    wait_idle();

    // Randomised traffic with random gaps (some back-to-back)
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 45)) @(negedge clk);
      send(4'($urandom), 3'($urandom_range(0, 7)));
    end
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
